link_sched: RTL and testbench

LINK_SCHED -- requirements
Module: link_sched

---
 rtl/link_sched.sv | 89 ++++++++
 tb/tb_link_sched.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/link_sched.sv
// link_sched: round-robin scheduler feeding one transmitter, with ack timeout and bounded retries.
module link_sched #(
    parameter logic [15:0] TIMEOUT = 16'd255,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [7:0] data0,
    input  logic [7:0] data1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       xmit_start,
    output logic [7:0] xmit_data,
    input  logic       xmit_done,
    input  logic       rcv_ack,
    output logic       sched_done,
    output logic       sched_err,
    output logic       sched_owner,
    output logic       sched_busy
);
    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, WAIT_ACK} state_t;
    state_t state, state_n;
    logic [15:0] timer, timer_n;
    logic [3:0] retry, retry_n;
    logic [7:0] data_n;
    logic rr, rr_n, owner_n, gnt0_n, gnt1_n, start_n, done_n, err_n;
    logic any_req, pick1, idle_go, ack_hit, time_hit, timeout, last;
    assign any_req = req0 | req1;
    // rr=1 gives requester 1 priority on a tie, i.e. requester 0 was granted last
    assign pick1 = req1 & (~req0 | rr);
    assign timeout = timer == TIMEOUT - 16'd1;
    assign last = retry == 4'(MAX_RETRY);
    assign idle_go = (state == IDLE) & any_req;
    assign ack_hit = (state == WAIT_ACK) & rcv_ack;
    assign time_hit = (state == WAIT_ACK) & ~rcv_ack & timeout;
    assign sched_busy = state != IDLE;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            timer <= '0;
            retry <= '0;
            rr <= 1'b0;
            xmit_data <= 8'h00;
            sched_owner <= 1'b0;
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
            xmit_start <= 1'b0;
            sched_done <= 1'b0;
            sched_err <= 1'b0;
        end else begin
            state <= state_n;
            timer <= timer_n;
            retry <= retry_n;
            rr <= rr_n;
            xmit_data <= data_n;
            sched_owner <= owner_n;
            gnt0 <= gnt0_n;
            gnt1 <= gnt1_n;
            xmit_start <= start_n;
            sched_done <= done_n;
            sched_err <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = any_req ? START : IDLE;
            START:     state_n = WAIT_DONE;
            WAIT_DONE: state_n = xmit_done ? WAIT_ACK : WAIT_DONE;
            WAIT_ACK:  state_n = rcv_ack ? IDLE : !timeout ? WAIT_ACK : last ? IDLE : START;
            default:   state_n = IDLE;
        endcase
    end
    always_comb begin
        gnt0_n = idle_go & ~pick1;
        gnt1_n = idle_go & pick1;
        data_n = idle_go ? (pick1 ? data1 : data0) : xmit_data;
        owner_n = idle_go ? pick1 : sched_owner;
        rr_n = idle_go ? ~pick1 : rr;
        start_n = state == START;
        done_n = ack_hit;
        err_n = time_hit & last;
        retry_n = (ack_hit | err_n) ? 4'd0 : time_hit ? retry + 4'd1 : retry;
        timer_n = ((state == WAIT_DONE) & xmit_done) ? 16'd0 :
                  ((state == WAIT_ACK) & ~rcv_ack) ? timer + 16'd1 : timer;
    end
endmodule

// File: tb/tb_link_sched.sv
// tb_link_sched: scoreboard bench; expected grants and outcomes are queued as stimulus is driven.
module tb_link_sched;
    logic clk = 1'b0, rst_n = 1'b0, req0 = 1'b0, req1 = 1'b0, xmit_done = 1'b0, rcv_ack = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic gnt0, gnt1, xmit_start, sched_done, sched_err, sched_owner, sched_busy;
    logic [7:0] xmit_data;
    typedef struct packed {logic own; logic [7:0] d;} gnt_t;
    gnt_t q_gnt[$];
    logic [1:0] q_out[$];
    logic [7:0] cur_data = 8'h00;
    int errors = 0, checks = 0, n_start = 0, n_done = 0, n_err = 0;
    int s0, d0, e0;

    link_sched #(.TIMEOUT(16'd4), .MAX_RETRY(2)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .xmit_start(xmit_start), .xmit_data(xmit_data),
        .xmit_done(xmit_done), .rcv_ack(rcv_ack), .sched_done(sched_done),
        .sched_err(sched_err), .sched_owner(sched_owner), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        gnt_t e;
        forever begin
            @(negedge clk);
            if (gnt0 | gnt1) begin
                if (q_gnt.size() == 0) check("gnt_unexpected", {30'd0, gnt1, gnt0}, 0);
                else begin
                    e = q_gnt.pop_front();
                    check("gnt_id", {30'd0, gnt1, gnt0}, e.own ? 2 : 1);
                    check("gnt_owner", {31'd0, sched_owner}, {31'd0, e.own});
                    check("gnt_data", {24'd0, xmit_data}, {24'd0, e.d});
                    cur_data = e.d;
                end
            end
            if (xmit_start) begin
                n_start++;
                check("xs_data", {24'd0, xmit_data}, {24'd0, cur_data});
            end
            if (sched_done | sched_err) begin
                n_done += int'(sched_done);
                n_err += int'(sched_err);
                if (q_out.size() == 0) check("outcome_unexpected", {30'd0, sched_err, sched_done}, 0);
                else check("outcome", {30'd0, sched_err, sched_done}, {30'd0, q_out.pop_front()});
            end
        end
    endtask

    task automatic wait_for(input int which, input string tag);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (which == 0 ? (gnt0 | gnt1) : which == 1 ? xmit_start : (sched_done | sched_err)) return;
        end
        check(tag, 0, 1);
    endtask

    task automatic pulse_done();
        xmit_done = 1'b1;
        @(negedge clk);
        xmit_done = 1'b0;
    endtask

    task automatic pulse_ack();
        rcv_ack = 1'b1;
        @(negedge clk);
        rcv_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        fork monitor(); join_none
        repeat (2) @(negedge clk);
        check("rst_outputs", {26'd0, gnt0, gnt1, xmit_start, sched_done, sched_err, sched_busy}, 0);
        check("rst_data", {24'd0, xmit_data}, 0);
        check("rst_owner", {31'd0, sched_owner}, 0);
        rst_n = 1'b1;
        // single transfer, with req1 toggled while busy
        req0 = 1'b1; data0 = 8'hA5;
        q_gnt.push_back(gnt_t'{1'b0, 8'hA5}); q_out.push_back(2'b01);
        @(negedge clk);
        check("t1_gnt0", {31'd0, gnt0}, 1);
        req0 = 1'b0; req1 = 1'b1; data1 = 8'hEE;
        @(negedge clk);
        check("t1_xs", {31'd0, xmit_start}, 1);
        check("t1_xd", {24'd0, xmit_data}, 8'hA5);
        req1 = 1'b0;
        pulse_done();
        pulse_ack();
        check("t1_done", {31'd0, sched_done}, 1);
        check("t1_owner", {31'd0, sched_owner}, 0);
        check("t1_busy", {31'd0, sched_busy}, 0);
        // tie: continuous requests alternate 0,1,0,1
        do_reset();
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h11; data1 = 8'h22;
        for (int i = 0; i < 4; i++) begin
            q_gnt.push_back(gnt_t'{i[0], i[0] ? 8'h22 : 8'h11});
            q_out.push_back(2'b01);
        end
        for (int i = 0; i < 4; i++) begin
            wait_for(0, "t2_gnt_timeout");
            wait_for(1, "t2_xs_timeout");
            pulse_done();
            pulse_ack();
        end
        req0 = 1'b0; req1 = 1'b0;
        // timeout retry: 3 attempts then error
        do_reset();
        @(negedge clk);
        s0 = n_start; d0 = n_done; e0 = n_err;
        req1 = 1'b1; data1 = 8'h5A;
        q_gnt.push_back(gnt_t'{1'b1, 8'h5A}); q_out.push_back(2'b10);
        wait_for(0, "t3_gnt_timeout");
        req1 = 1'b0;
        repeat (3) begin
            wait_for(1, "t3_xs_timeout");
            pulse_done();
        end
        wait_for(2, "t3_err_timeout");
        check("t3_err", {31'd0, sched_err}, 1);
        repeat (10) @(negedge clk);
        check("t3_starts", n_start - s0, 3);
        check("t3_errs", n_err - e0, 1);
        check("t3_dones", n_done - d0, 0);
        // ack on the exact timeout cycle
        s0 = n_start;
        req0 = 1'b1; data0 = 8'h3C;
        q_gnt.push_back(gnt_t'{1'b0, 8'h3C}); q_out.push_back(2'b01);
        wait_for(0, "t4_gnt_timeout");
        req0 = 1'b0;
        wait_for(1, "t4_xs_timeout");
        pulse_done();
        repeat (3) @(negedge clk);
        pulse_ack();
        check("t4_done", {31'd0, sched_done}, 1);
        check("t4_err", {31'd0, sched_err}, 0);
        repeat (10) @(negedge clk);
        check("t4_starts", n_start - s0, 1);
        // reset in WAIT_ACK aborts silently; tie afterwards goes to requester 0
        req0 = 1'b1; data0 = 8'h77;
        q_gnt.push_back(gnt_t'{1'b0, 8'h77});
        wait_for(0, "t5_gnt_timeout");
        req0 = 1'b0;
        wait_for(1, "t5_xs_timeout");
        pulse_done();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5_busy", {31'd0, sched_busy}, 0);
        check("t5_data", {24'd0, xmit_data}, 0);
        check("t5_owner", {31'd0, sched_owner}, 0);
        check("t5_pulses", {30'd0, sched_done, sched_err}, 0);
        rst_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1; data0 = 8'h09; data1 = 8'h99;
        q_gnt.push_back(gnt_t'{1'b0, 8'h09}); q_out.push_back(2'b01);
        wait_for(0, "t5_gnt2_timeout");
        req0 = 1'b0; req1 = 1'b0;
        wait_for(1, "t5_xs2_timeout");
        pulse_done();
        pulse_ack();
        check("t5_done", {31'd0, sched_done}, 1);
        // stray ack/done in IDLE
        @(negedge clk);
        s0 = n_start; d0 = n_done; e0 = n_err;
        rcv_ack = 1'b1; xmit_done = 1'b1;
        @(negedge clk);
        rcv_ack = 1'b0; xmit_done = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_busy", {31'd0, sched_busy}, 0);
        check("t6_data", {24'd0, xmit_data}, 8'h09);
        check("t6_owner", {31'd0, sched_owner}, 0);
        check("t6_starts", n_start - s0, 0);
        check("t6_outcomes", (n_done - d0) + (n_err - e0), 0);
        check("q_gnt_left", q_gnt.size(), 0);
        check("q_out_left", q_out.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
